// File: rtl/level_sequencer_pkg.sv
// Shared types and level codes for the memory-game controller.
`default_nettype none

package memory_game_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHOW  = 3'd1,
      INPUT = 3'd2,
      CHECK = 3'd3,
      WIN   = 3'd4,
      LOSE  = 3'd5
   } state_t;

   localparam logic [1:0] LEVEL_OFF = 2'b00;
   localparam logic [1:0] LEVEL_1   = 2'b01;
   localparam logic [1:0] LEVEL_2   = 2'b10;
   localparam logic [1:0] LEVEL_3   = 2'b11;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/level_sequencer_if.sv
// Player-facing control inputs and display-facing status outputs of the game controller.
`default_nettype none

interface level_sequencer_if;

   logic       start;
   logic       abort;
   logic       answer_valid;
   logic       answer_ok;
   logic [1:0] level;
   logic       show_en;
   logic       input_en;
   logic [1:0] round_idx;
   logic [2:0] lives_left;
   logic       game_won;
   logic       game_over;

   modport master (
      output start, abort, answer_valid, answer_ok,
      input  level, show_en, input_en, round_idx, lives_left, game_won, game_over
   );

   modport slave (
      input  start, abort, answer_valid, answer_ok,
      output level, show_en, input_en, round_idx, lives_left, game_won, game_over
   );

endinterface

`default_nettype wire

// File: rtl/level_sequencer_phase_timer.sv
// Loadable down-counter shared by the pattern-display and player-input phases.
`default_nettype none

module phase_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/level_sequencer.sv
// Memory-game round/level sequencer: show pattern, accept answer, score, advance or lose lives.
`default_nettype none

module level_sequencer
   import memory_game_pkg::*;
#(
   parameter int ROUNDS_PER_LEVEL = 3,
   parameter int LIVES            = 3,
   parameter int SHOW_CYCLES      = 100000000,
   parameter int INPUT_TIMEOUT    = 500000000
) (
   input  logic               clk,
   input  logic               reset_n,
   level_sequencer_if.slave   bus
);

   localparam int TIMER_MAX = max_int(SHOW_CYCLES, INPUT_TIMEOUT);
   localparam int TW        = $clog2(TIMER_MAX + 1);

   // Timer counts down to zero inclusive, so load N-1 for an N-cycle phase.
   localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
   localparam logic [TW-1:0] INPUT_LOAD = TW'(INPUT_TIMEOUT - 1);
   localparam logic [1:0]    ROUND_LAST = 2'(ROUNDS_PER_LEVEL - 1);
   localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

   state_t     state, state_nx;
   logic [1:0] level_nx, round_nx;
   logic [2:0] lives_nx;
   logic       ok_q, ok_nx;
   logic       timer_load, timer_done;
   logic [TW-1:0] timer_value;

   phase_timer #(.WIDTH(TW)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   always_comb begin
      state_nx    = state;
      level_nx    = bus.level;
      round_nx    = bus.round_idx;
      lives_nx    = bus.lives_left;
      ok_nx       = ok_q;
      timer_load  = 1'b0;
      timer_value = SHOW_LOAD;

      if (bus.abort) begin
         state_nx    = IDLE;
         level_nx    = LEVEL_OFF;
         round_nx    = 2'd0;
         lives_nx    = LIVES_INIT;
         ok_nx       = 1'b0;
         timer_load  = 1'b1;
         timer_value = '0;
      end else begin
         case (state)
            IDLE, WIN, LOSE: begin
               if (bus.start) begin
                  state_nx   = SHOW;
                  level_nx   = LEVEL_1;
                  round_nx   = 2'd0;
                  lives_nx   = LIVES_INIT;
                  timer_load = 1'b1;
               end
            end
            SHOW: begin
               if (timer_done) begin
                  state_nx    = INPUT;
                  timer_load  = 1'b1;
                  timer_value = INPUT_LOAD;
               end
            end
            INPUT: begin
               // A real answer on the expiry cycle takes precedence over the timeout.
               if (bus.answer_valid) begin
                  state_nx = CHECK;
                  ok_nx    = bus.answer_ok;
               end else if (timer_done) begin
                  state_nx = CHECK;
                  ok_nx    = 1'b0;
               end
            end
            CHECK: begin
               if (ok_q) begin
                  if (bus.round_idx < ROUND_LAST) begin
                     round_nx   = bus.round_idx + 2'd1;
                     state_nx   = SHOW;
                     timer_load = 1'b1;
                  end else if (bus.level != LEVEL_3) begin
                     level_nx   = bus.level + 2'd1;
                     round_nx   = 2'd0;
                     state_nx   = SHOW;
                     timer_load = 1'b1;
                  end else begin
                     state_nx = WIN;
                  end
               end else if (bus.lives_left > 3'd1) begin
                  lives_nx   = bus.lives_left - 3'd1;
                  state_nx   = SHOW;
                  timer_load = 1'b1;
               end else begin
                  lives_nx = 3'd0;
                  state_nx = LOSE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         ok_q           <= 1'b0;
         bus.level      <= LEVEL_OFF;
         bus.round_idx  <= 2'd0;
         bus.lives_left <= LIVES_INIT;
         bus.show_en    <= 1'b0;
         bus.input_en   <= 1'b0;
         bus.game_won   <= 1'b0;
         bus.game_over  <= 1'b0;
      end else begin
         state          <= state_nx;
         ok_q           <= ok_nx;
         bus.level      <= level_nx;
         bus.round_idx  <= round_nx;
         bus.lives_left <= lives_nx;
         bus.show_en    <= (state_nx == SHOW);
         bus.input_en   <= (state_nx == INPUT);
         bus.game_won   <= (state_nx == WIN);
         bus.game_over  <= (state_nx == LOSE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a cycle-level game model and literal spot checks.
`default_nettype none

module tb_level_sequencer;

   localparam int R = 2;
   localparam int L = 3;
   localparam int S = 4;
   localparam int T = 8;

   localparam int P_IDLE  = 0;
   localparam int P_SHOW  = 1;
   localparam int P_INPUT = 2;
   localparam int P_CHECK = 3;
   localparam int P_WIN   = 4;
   localparam int P_LOSE  = 5;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   level_sequencer_if bus ();

   level_sequencer #(
      .ROUNDS_PER_LEVEL (R),
      .LIVES            (L),
      .SHOW_CYCLES      (S),
      .INPUT_TIMEOUT    (T)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Game model: phase plus cycles remaining in that phase, and game score variables.
   int m_phase, m_left, m_level, m_round, m_lives;
   bit m_ok;

   task automatic model_init();
      m_phase = P_IDLE; m_left = 0; m_level = 0; m_round = 0; m_lives = L; m_ok = 0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_init();
      end else if (bus.abort) begin
         model_init();
      end else begin
         case (m_phase)
            P_IDLE, P_WIN, P_LOSE:
               if (bus.start) begin
                  m_phase = P_SHOW; m_left = S; m_level = 1; m_round = 0; m_lives = L;
               end
            P_SHOW: begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_phase = P_INPUT; m_left = T; end
            end
            P_INPUT:
               if (bus.answer_valid) begin
                  m_phase = P_CHECK; m_ok = bus.answer_ok;
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin m_phase = P_CHECK; m_ok = 0; end
               end
            P_CHECK:
               if (m_ok) begin
                  if (m_round + 1 < R) begin
                     m_round = m_round + 1; m_phase = P_SHOW; m_left = S;
                  end else if (m_level < 3) begin
                     m_level = m_level + 1; m_round = 0; m_phase = P_SHOW; m_left = S;
                  end else begin
                     m_phase = P_WIN;
                  end
               end else if (m_lives > 1) begin
                  m_lives = m_lives - 1; m_phase = P_SHOW; m_left = S;
               end else begin
                  m_lives = 0; m_phase = P_LOSE;
               end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (reset_n) begin
         check("level",      32'(bus.level),      32'(m_phase == P_IDLE ? 0 : m_level));
         check("show_en",    32'(bus.show_en),    32'(m_phase == P_SHOW));
         check("input_en",   32'(bus.input_en),   32'(m_phase == P_INPUT));
         check("round_idx",  32'(bus.round_idx),  32'(m_round));
         check("lives_left", 32'(bus.lives_left), 32'(m_lives));
         check("game_won",   32'(bus.game_won),   32'(m_phase == P_WIN));
         check("game_over",  32'(bus.game_over),  32'(m_phase == P_LOSE));
      end
   end

   task automatic bound_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t, got timeout, expected event", name, $time);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_input();
      int n = 0;
      while (bus.input_en !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) bound_fail("wait_input");
   endtask

   task automatic answer(input bit ok, input int delay);
      wait_input();
      repeat (delay) @(negedge clk);
      bus.answer_valid = 1'b1;
      bus.answer_ok    = ok;
      @(negedge clk);
      bus.answer_valid = 1'b0;
      bus.answer_ok    = 1'b0;
   endtask

   initial begin
      int n;
      n_cmp = 0;
      n_bad = 0;
      bus.start = 0; bus.abort = 0; bus.answer_valid = 0; bus.answer_ok = 0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_level", 32'(bus.level), 0);
      check("rst_lives", 32'(bus.lives_left), 3);
      reset_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of SHOW.
      pulse_start();
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("async_rst_level",   32'(bus.level),   0);
      check("async_rst_show_en", 32'(bus.show_en), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      pulse_start();
      check("start_level", 32'(bus.level), 1);
      n = 0;
      while (bus.show_en === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("show_len", 32'(n), 4);

      // Perfect game: six correct answers, two per level.
      for (int i = 0; i < 6; i++) answer(1'b1, 2);
      @(negedge clk);
      check("win_flag",  32'(bus.game_won), 1);
      check("win_level", 32'(bus.level), 3);
      repeat (3) @(negedge clk);
      check("win_hold",  32'(bus.game_won), 1);

      // Wrong answer at level 2, round 1.
      pulse_start();
      for (int i = 0; i < 3; i++) answer(1'b1, 2);
      answer(1'b0, 2);
      @(negedge clk);
      check("wrong_lives", 32'(bus.lives_left), 2);
      check("wrong_level", 32'(bus.level), 2);
      check("wrong_round", 32'(bus.round_idx), 1);
      check("wrong_show",  32'(bus.show_en), 1);

      // Three timeouts end the game.
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         wait_input();
         n = 0;
         while (bus.input_en === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) bound_fail("timeout_exit");
      end
      @(negedge clk);
      check("lose_flag",  32'(bus.game_over), 1);
      check("lose_lives", 32'(bus.lives_left), 0);
      pulse_start();
      check("restart_level", 32'(bus.level), 1);
      check("restart_lives", 32'(bus.lives_left), 3);
      check("restart_over",  32'(bus.game_over), 0);

      // Answer lands on the exact expiry cycle.
      answer(1'b1, T - 1);
      @(negedge clk);
      check("edge_lives", 32'(bus.lives_left), 3);
      check("edge_round", 32'(bus.round_idx), 1);

      // Climb to level 3, then abort during INPUT.
      for (int i = 0; i < 3; i++) answer(1'b1, 1);
      wait_input();
      check("pre_abort_level", 32'(bus.level), 3);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_level", 32'(bus.level), 0);
      check("abort_input", 32'(bus.input_en), 0);

      // Stray answers in IDLE and SHOW are ignored.
      bus.answer_valid = 1'b1;
      bus.answer_ok    = 1'b1;
      @(negedge clk);
      bus.answer_valid = 1'b0;
      bus.answer_ok    = 1'b0;
      pulse_start();
      bus.answer_valid = 1'b1;
      @(negedge clk);
      bus.answer_valid = 1'b0;
      check("stray_show",  32'(bus.show_en), 1);
      check("stray_lives", 32'(bus.lives_left), 3);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
